// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios parallel I/O ports: register map and
// edge-capture encodings used by the input/output ports and driver headers.
package nios_pio_pkg;

   localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
   localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
   localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

   localparam int PIO_EDGE_RISING  = 0;
   localparam int PIO_EDGE_FALLING = 1;
   localparam int PIO_EDGE_ANY     = 2;

   typedef enum logic {
      DB_IDLE,
      DB_COUNTING
   } db_state_e;

   // Edge event for one bit given the current and previous debounced value.
   function automatic logic pio_edge_event(input int edge_type, input logic cur, input logic prev);
      logic rise;
      logic fall;
      rise = cur & ~prev;
      fall = ~cur & prev;
      if (edge_type == PIO_EDGE_RISING)
         return rise;
      else if (edge_type == PIO_EDGE_FALLING)
         return fall;
      else
         return rise | fall;
   endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// One input bit: 2-flop synchronizer followed by a counter-based debouncer
// that accepts a new level only after DEBOUNCE_CYCLES consecutive samples.
module pio_in_debounce
   import nios_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_meta;
   logic          sync;
   logic [CW-1:0] cnt;
   db_state_e     state;

   // A mismatch that disappears before the count completes drops back to IDLE
   // with a zero count, so a glitch never accumulates across separate pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
         stable    <= 1'b0;
         cnt       <= '0;
         state     <= DB_IDLE;
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
         case (state)
            DB_IDLE: begin
               if (sync != stable) begin
                  if (cnt == CNT_LAST) begin
                     stable <= sync;
                     cnt    <= '0;
                  end else begin
                     cnt   <= cnt + 1'b1;
                     state <= DB_COUNTING;
                  end
               end
            end
            DB_COUNTING: begin
               if (sync == stable) begin
                  cnt   <= '0;
                  state <= DB_IDLE;
               end else if (cnt == CNT_LAST) begin
                  stable <= sync;
                  cnt    <= '0;
                  state  <= DB_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= DB_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/nios_system_keys_in.sv
// Avalon-MM input port: debounced key/switch inputs, edge capture register
// with write-1-to-clear, interrupt mask and a level interrupt.
module nios_system_keys_in
   import nios_pio_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] cap_clr;
   logic             wr_en;
   logic             unused_wdata;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         pio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (in_port[i]),
            .stable(stable[i])
         );
      end
   endgenerate

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      edge_evt = '0;
      cap_clr  = '0;
      for (int i = 0; i < WIDTH; i++)
         edge_evt[i] = pio_edge_event(EDGE_TYPE, stable[i], prev[i]);
      if (wr_en && address == PIO_ADDR_EDGECAP)
         cap_clr = writedata[WIDTH-1:0];
   end

   // A new event is OR-ed in after the clear so that a same-cycle event wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev     <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         prev     <= stable;
         edge_cap <= (edge_cap & ~cap_clr) | edge_evt;
         if (wr_en && address == PIO_ADDR_IRQMASK)
            irq_mask <= writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         PIO_ADDR_DATA:    readdata = 32'(stable);
         PIO_ADDR_IRQMASK: readdata = 32'(irq_mask);
         PIO_ADDR_EDGECAP: readdata = 32'(edge_cap);
         default:          readdata = '0;
      endcase
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_nios_system_keys_in.sv
// Bench for nios_system_keys_in: three instances (rising, falling, any edge)
// share the inputs and are compared every cycle against a window-based model.
module tb_nios_system_keys_in;

   localparam int W = 4;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [W-1:0] in_port;
   logic [31:0] rd0, rd1, rd2;
   logic        irq0, irq1, irq2;

   int checks = 0;
   int errors = 0;

   // Model: DATA flips a bit when the last D synchronized samples all differ from it.
   logic [W-1:0] m_data, m_prev, m_mask, h1, h2;
   logic [W-1:0] m_cap [3];
   logic [W-1:0] win [$];
   bit           model_valid = 0;

   always #5 clk = ~clk;

   nios_system_keys_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) dut_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
   nios_system_keys_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) dut_fall (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
   nios_system_keys_in #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) dut_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rd_sel(input int k);
      return (k == 0) ? rd0 : (k == 1) ? rd1 : rd2;
   endfunction

   function automatic logic irq_sel(input int k);
      return (k == 0) ? irq0 : (k == 1) ? irq1 : irq2;
   endfunction

   function automatic logic [W-1:0] model_event(input int k);
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      rise = m_data & ~m_prev;
      fall = ~m_data & m_prev;
      if (k == 0) return rise;
      if (k == 1) return fall;
      return rise | fall;
   endfunction

   function automatic logic [31:0] model_rd(input int k);
      case (address)
         2'd0:    return {28'b0, m_data};
         2'd2:    return {28'b0, m_mask};
         2'd3:    return {28'b0, m_cap[k]};
         default: return 32'b0;
      endcase
   endfunction

   task automatic apply_stimulus(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] d);
      chipselect = cs;
      write_n    = wn;
      address    = a;
      writedata  = d;
   endtask

   // Advance one cycle: compare all instances, then step the model with the sampled inputs.
   task automatic tick();
      logic [W-1:0] all_diff, clr, n_data, n_mask;
      logic [W-1:0] n_cap [3];
      bit wr;
      #1;
      if (model_valid) begin
         for (int k = 0; k < 3; k++) begin
            check_output($sformatf("rd%0d_a%0d", k, address), rd_sel(k), model_rd(k));
            check_output($sformatf("irq%0d", k), {31'b0, irq_sel(k)}, {31'b0, |(m_cap[k] & m_mask)});
         end
      end
      if (reset) begin
         n_data = '0; n_mask = '0;
         for (int k = 0; k < 3; k++) n_cap[k] = '0;
         win.delete();
      end else begin
         win.push_back(h2);
         if (win.size() > D) win.delete(0);
         all_diff = '1;
         foreach (win[i]) all_diff &= win[i] ^ m_data;
         if (win.size() < D) all_diff = '0;
         n_data = m_data ^ all_diff;
         wr     = chipselect && !write_n;
         n_mask = (wr && address == 2'd2) ? writedata[W-1:0] : m_mask;
         clr    = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
         for (int k = 0; k < 3; k++) n_cap[k] = (m_cap[k] & ~clr) | model_event(k);
      end
      @(posedge clk);
      m_prev = reset ? '0 : m_data;
      h2     = reset ? '0 : h1;
      h1     = reset ? '0 : in_port;
      m_data = n_data;
      m_mask = n_mask;
      for (int k = 0; k < 3; k++) m_cap[k] = n_cap[k];
      if (reset) model_valid = 1;
      @(negedge clk);
   endtask

   task automatic peek(input string tag, input int k, input logic [1:0] a, input logic [31:0] exp);
      apply_stimulus(1'b1, 1'b1, a, 32'b0);
      #1;
      check_output(tag, rd_sel(k), exp);
   endtask

   initial begin
      reset = 1'b1;
      in_port = '0;
      apply_stimulus(1'b0, 1'b1, 2'd0, 32'b0);
      @(negedge clk);
      tick();
      tick();
      reset = 1'b0;

      for (int a = 0; a < 4; a++) begin
         peek($sformatf("reset_rd_a%0d", a), 0, 2'(a), 32'h0);
         check_output("reset_irq", {31'b0, irq0}, 32'h0);
         tick();
      end
      apply_stimulus(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF);
      tick();
      peek("data_write_ignored", 0, 2'd0, 32'h0);
      tick();

      // Three-cycle glitch on bit 0 must never reach DATA.
      in_port = 4'b0001;
      repeat (3) tick();
      in_port = 4'b0000;
      repeat (8) tick();
      peek("glitch_data", 0, 2'd0, 32'h0);
      tick();
      peek("glitch_cap", 0, 2'd3, 32'h0);
      tick();

      apply_stimulus(1'b1, 1'b0, 2'd2, 32'h1);
      tick();
      in_port = 4'b0101;
      apply_stimulus(1'b1, 1'b1, 2'd0, 32'b0);
      repeat (5) tick();
      peek("press_early", 0, 2'd0, 32'h0);
      tick();
      peek("press_data", 0, 2'd0, 32'h5);
      check_output("press_irq_early", {31'b0, irq0}, 32'h0);
      tick();
      peek("press_cap", 0, 2'd3, 32'h5);
      check_output("press_irq", {31'b0, irq0}, 32'h1);
      tick();

      in_port = 4'b0000;
      repeat (12) tick();
      peek("release_cap", 0, 2'd3, 32'h5);
      tick();

      apply_stimulus(1'b1, 1'b0, 2'd3, 32'h1);
      tick();
      peek("clear1_cap", 0, 2'd3, 32'h4);
      check_output("clear1_irq", {31'b0, irq0}, 32'h0);
      tick();
      apply_stimulus(1'b1, 1'b0, 2'd3, 32'h4);
      tick();
      peek("clear4_cap", 0, 2'd3, 32'h0);
      tick();

      // Bit-2 event lands in cycle s+6, same cycle as its clear.
      in_port = 4'b0100;
      apply_stimulus(1'b1, 1'b1, 2'd0, 32'b0);
      repeat (6) tick();
      apply_stimulus(1'b1, 1'b0, 2'd3, 32'h4);
      tick();
      peek("collide_cap", 0, 2'd3, 32'h4);
      tick();

      in_port = 4'b0000;
      repeat (12) tick();
      apply_stimulus(1'b1, 1'b0, 2'd3, 32'hF);
      tick();

      // Reset while the bit-1 count sits at 2; debounce restarts afterwards.
      in_port = 4'b0010;
      apply_stimulus(1'b1, 1'b1, 2'd0, 32'b0);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (5) tick();
      peek("midreset_hold", 2, 2'd0, 32'h0);
      tick();
      peek("midreset_data", 2, 2'd0, 32'h2);
      tick();
      peek("any_rise_cap", 2, 2'd3, 32'h2);
      tick();
      apply_stimulus(1'b1, 1'b0, 2'd3, 32'hF);
      tick();
      in_port = 4'b0000;
      apply_stimulus(1'b1, 1'b1, 2'd0, 32'b0);
      repeat (6) tick();
      tick();
      peek("any_fall_cap", 2, 2'd3, 32'h2);
      tick();
      peek("rise_no_fall_cap", 0, 2'd3, 32'h0);
      tick();

      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 7) == 0) in_port = 4'($urandom);
         apply_stimulus(1'($urandom), 1'($urandom), 2'($urandom), $urandom);
         reset = ($urandom_range(0, 199) == 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nios_system_keys_in.md
# nios_system_keys_in

Avalon-MM slave input port for the Nios system: samples up to 32 external inputs (push-buttons, switches), synchronizes and debounces them, latches edges into a capture register and raises a maskable interrupt. Complements the LED output port: same address map style, same zero-wait-state bus timing, attached to the system interconnect as a single 4-word slave.

## Interface
- `WIDTH`, 4: number of input bits, 1..32.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required before a change is accepted. Minimum 1.
- `EDGE_TYPE`, 0: edge captured. 0 = rising, 1 = falling, 2 = any.
- `clk`, input, 1: system clock. All logic is in this one clock domain.
- `reset`, input, 1: synchronous, active-high reset.
- `address`, input, 2: word address.
- `chipselect`, input, 1: slave select.
- `write_n`, input, 1: active-low write strobe, qualified by `chipselect`.
- `writedata`, input, 32: write data.
- `in_port`, input, WIDTH: raw asynchronous inputs.
- `readdata`, output, 32: read data, zero-extended.
- `irq`, output, 1: interrupt request, level.

## Operation
- Register map:
  - 0 DATA: read-only debounced value. Writes are ignored.
  - 1 reserved: reads 0. Writes are ignored.
  - 2 IRQMASK: read/write, WIDTH bits.
  - 3 EDGECAP: read, or write-1-to-clear per bit.
- Write takes effect when `chipselect && !write_n`. `writedata[31:WIDTH]` is ignored.
- Per bit, input path is: 2-flop synchronizer → debouncer → edge detector.
- Debouncer per bit:
  - Holds `stable` and counter `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - While `sync == stable`, `cnt` = 0.
  - While `sync != stable`, `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1`, `stable` <= `sync` and `cnt` <= 0 in the same cycle.
  - Any glitch shorter than DEBOUNCE_CYCLES returns `cnt` to 0.
  - States per bit: IDLE (`cnt` == 0, match) and COUNTING. No other state.
- Edge detector: `prev` <= `stable` every cycle.
  - Rising event = `stable & ~prev`.
  - Falling event = `~stable & prev`.
  - Any = XOR.
- EDGECAP bit sets on an event and holds until software clears it.
- Same-cycle event and write-1-to-clear on the same bit: set wins, bit stays 1.
- `irq` = `|(EDGECAP & IRQMASK)`, decoded combinationally from registers.
- Reset clears synchronizers, `stable`, `prev`, `cnt`, IRQMASK and EDGECAP. Outputs after reset: `readdata` = 0 (all registers 0), `irq` = 0.
- An input held high through reset yields one rising event after debounce. This is intended: software clears EDGECAP at init.
- Reset asserted mid-debounce discards the partial count.

## Timing
- Read latency 0: `readdata` is a combinational mux of `address` over registers, valid in the same cycle. No waitrequest.
- `readdata` is driven regardless of `chipselect`; the interconnect qualifies it.
- Write latency 1: the register updates on the clock edge where the write is sampled, and the new value is readable the next cycle.
- Input to DATA latency: a change stable from cycle t appears in DATA at t+2+DEBOUNCE_CYCLES.
- EDGECAP bit and `irq` rise one cycle after DATA changes.
- IRQMASK write enabling a pending bit: `irq` rises the cycle after the write.
- EDGECAP clear write: `irq` falls the cycle after the write, unless a new event arrives in the same cycle.

## Structure
- Shared package `nios_pio_pkg` holds:
  - Register address constants (`PIO_ADDR_DATA`=0, `PIO_ADDR_IRQMASK`=2, `PIO_ADDR_EDGECAP`=3), shared with the output port and driver headers.
  - `EDGE_TYPE` encodings.
- Sub-module `pio_in_debounce`: one bit, containing synchronizer, counter and `stable`. Instantiated WIDTH times via generate.
- Edge capture, mask and bus decode stay in the top level.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4.
- Reset with `in_port`=0. Read addresses 0..3 → all 0, `irq`=0. Then write 0xFFFF_FFFF to address 0 → DATA still 0.
- Glitch: `in_port[0]` high for 3 cycles, then low → DATA stays 0 and EDGECAP stays 0.
- Clean press, EDGE_TYPE=0: `in_port` = 4'b0101 held from cycle t.
  - DATA = 0x5 at t+6.
  - EDGECAP = 0x5 at t+7.
  - With IRQMASK = 0x1, `irq`=1 at t+7.
  - Release produces no new capture.
- Clear: with EDGECAP=0x5, write 0x1 to address 3 → EDGECAP=0x4 and `irq`=0 next cycle. Write 0x4 → EDGECAP=0.
- Collision: schedule a bit-2 rising event in the same cycle as a write of 0x4 to address 3 → EDGECAP[2]=1 afterward.
- EDGE_TYPE=2 and mid-debounce reset:
  - Toggle bit 1 up, then down, each held 10 cycles → EDGECAP[1] sets on both transitions.
  - Assert `reset` at `cnt`=2 → DATA stays 0 and the count restarts from 0.
